// File: rtl/ins_mem_responder.sv
// Instruction-memory responder: fixed-latency fetch of 16-bit words
// behind the control unit's en_ram_in/en_ram_out handshake, with preload port.
module ins_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [ADDR_W-1:0] pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic [15:0]       ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      CNT_LD  = 3'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ins_q, ins_d;
  logic              err_q, err_d;
  logic              strb_q, strb_d;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic [15:0]       rd_word;
  logic              wr_ok;

  // IDLE reads pc directly so a single-cycle latency can fire on acceptance.
  assign rd_addr = (state_q == IDLE) ? pc : addr_q;
  assign rd_ok   = {1'b0, rd_addr} < DEPTH_C;
  assign rd_word = rd_ok ? mem[rd_addr] : 16'h0000;
  assign wr_ok   = {1'b0, load_addr} < DEPTH_C;

  always_ff @(posedge clk) begin
    if (rst && load_en && wr_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    err_d   = 1'b0;
    strb_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_ram_in) begin
          addr_d = pc;
          if (LATENCY == 1) begin
            state_d = RESP;
            ins_d   = rd_word;
            err_d   = !rd_ok;
            strb_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Final WAIT edge: the counter reaches zero as the array is read.
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          ins_d   = rd_word;
          err_d   = !rd_ok;
          strb_d  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      ins_q   <= 16'h0000;
      err_q   <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  assign ins        = ins_q;
  assign en_ram_out = strb_q;
  assign addr_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ins_mem_responder.sv
// Scoreboard bench for ins_mem_responder: three instances
// (latency 2 / 1 / 7, DEPTH 200) sharing reset, pc and preload port.
module tb_ins_mem_responder;

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1, en7;
  logic [7:0]  pc;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] ins0, ins1, ins7;
  logic        str0, str1, str7;
  logic        busy0, busy1, busy7;
  logic        err0, err1, err7;

  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q7[$];
  exp_t m_ex;
  bit   m_h;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ins_mem_responder #(.ADDR_W(8), .DEPTH(200), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .en_ram_in(en0), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ins(ins0), .en_ram_out(str0), .busy(busy0), .addr_err(err0)
  );

  ins_mem_responder #(.ADDR_W(8), .DEPTH(200), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en_ram_in(en1), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ins(ins1), .en_ram_out(str1), .busy(busy1), .addr_err(err1)
  );

  ins_mem_responder #(.ADDR_W(8), .DEPTH(200), .LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst), .en_ram_in(en7), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ins(ins7), .en_ram_out(str7), .busy(busy7), .addr_err(err7)
  );

  task automatic check_resp(input string nm, input bit have,
                            input exp_t ex, input logic [15:0] d,
                            input logic e);
    total++;
    if (!have) begin
      $display("FAIL %s resp: unexpected strobe cyc %0d ins %h", nm, cyc, d);
    end else if (ex.due != cyc || ex.d !== d || ex.e !== e) begin
      $display("FAIL %s resp: got cyc %0d ins %h err %b, want cyc %0d ins %h err %b",
               nm, cyc, d, e, ex.due, ex.d, ex.e);
    end else begin
      pass++;
    end
  endtask

  always @(negedge clk) begin
    if (str0 === 1'b1) begin
      m_h = q0.size() > 0;
      if (m_h) m_ex = q0.pop_front();
      check_resp("lat2", m_h, m_ex, ins0, err0);
    end
    if (str1 === 1'b1) begin
      m_h = q1.size() > 0;
      if (m_h) m_ex = q1.pop_front();
      check_resp("lat1", m_h, m_ex, ins1, err1);
    end
    if (str7 === 1'b1) begin
      m_h = q7.size() > 0;
      if (m_h) m_ex = q7.pop_front();
      check_resp("lat7", m_h, m_ex, ins7, err7);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      $display("FAIL %s: got %h want %h", nm, got, want);
    end else begin
      pass++;
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic fetch0(input logic [7:0] a, input logic [15:0] d,
                        input logic e);
    pc  = a;
    en0 = 1'b1;
    q0.push_back('{cyc + 2, d, e});
    tick();
    en0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic pend(input string nm, input int n);
    total++;
    if (n != 0) begin
      $display("FAIL %s pending: %0d responses missing", nm, n);
    end else begin
      pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    en0 = 1'b0; en1 = 1'b0; en7 = 1'b0;
    pc = 8'd0;
    load_en = 1'b0; load_addr = 8'd0; load_data = 16'h0000;
    tick();
    tick();
    chk("rst ins", ins0, 32'h0);
    chk("rst strobe", str0, 32'h0);
    chk("rst busy", busy0, 32'h0);
    chk("rst err", err0, 32'h0);
    rst = 1'b1;

    load(8'd3, 16'h1234);
    load(8'd0, 16'hA000);
    load(8'd1, 16'hA001);
    load(8'd2, 16'hA002);
    load(8'd10, 16'h1010);
    load(8'd50, 16'h1111);
    load(8'd199, 16'hC199);
    load(8'd250, 16'hBEEF);

    // basic fetch
    pc  = 8'd3;
    en0 = 1'b1;
    q0.push_back('{cyc + 2, 16'h1234, 1'b0});
    tick();
    en0 = 1'b0;
    chk("basic busy k+1", busy0, 32'h1);
    chk("basic strobe k+1", str0, 32'h0);
    tick();
    chk("basic busy k+2", busy0, 32'h1);
    tick();
    chk("basic busy k+3", busy0, 32'h0);
    chk("basic strobe k+3", str0, 32'h0);
    chk("basic ins held", ins0, 32'h1234);

    // streaming with en held high
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i);
      q0.push_back('{cyc + 2, 16'hA000 + 16'(i), 1'b0});
      tick();
      tick();
      tick();
    end
    en0 = 1'b0;
    tick();

    // collision: write one cycle after acceptance is not seen
    load(8'd5, 16'hAAAA);
    pc  = 8'd5;
    en0 = 1'b1;
    q0.push_back('{cyc + 2, 16'hAAAA, 1'b0});
    tick();
    en0 = 1'b0;
    load(8'd5, 16'h5555);
    tick();
    fetch0(8'd5, 16'h5555, 1'b0);

    // collision: write in the acceptance cycle is seen
    load(8'd5, 16'hAAAA);
    pc        = 8'd5;
    en0       = 1'b1;
    load_en   = 1'b1;
    load_addr = 8'd5;
    load_data = 16'h5555;
    q0.push_back('{cyc + 2, 16'h5555, 1'b0});
    tick();
    en0     = 1'b0;
    load_en = 1'b0;
    tick();
    tick();

    // range boundaries
    fetch0(8'd250, 16'h0000, 1'b1);
    chk("oor err cleared", err0, 32'h0);
    chk("oor ins held", ins0, 32'h0);
    fetch0(8'd50, 16'h1111, 1'b0);
    fetch0(8'd200, 16'h0000, 1'b1);
    fetch0(8'd199, 16'hC199, 1'b0);

    // latency 1: back-to-back every 2 cycles
    pc  = 8'd10;
    en1 = 1'b1;
    q1.push_back('{cyc + 1, 16'h1010, 1'b0});
    tick();
    chk("lat1 busy k+1", busy1, 32'h1);
    tick();
    chk("lat1 busy k+2", busy1, 32'h0);
    q1.push_back('{cyc + 1, 16'h1010, 1'b0});
    tick();
    en1 = 1'b0;
    tick();
    chk("lat1 idle after", busy1, 32'h0);

    // latency 7
    pc  = 8'd10;
    en7 = 1'b1;
    q7.push_back('{cyc + 7, 16'h1010, 1'b0});
    tick();
    en7 = 1'b0;
    chk("lat7 busy k+1", busy7, 32'h1);
    repeat (5) tick();
    chk("lat7 strobe k+6", str7, 32'h0);
    tick();
    chk("lat7 busy k+7", busy7, 32'h1);
    tick();
    chk("lat7 busy k+8", busy7, 32'h0);

    // reset mid-fetch, then immediate refetch
    pc  = 8'd3;
    en0 = 1'b1;
    en7 = 1'b1;
    tick();
    en0       = 1'b0;
    en7       = 1'b0;
    rst       = 1'b0;
    load_en   = 1'b1;
    load_addr = 8'd3;
    load_data = 16'hDEAD;
    tick();
    chk("rst2 busy lat2", busy0, 32'h0);
    chk("rst2 busy lat7", busy7, 32'h0);
    tick();
    chk("rst2 ins", ins0, 32'h0);
    chk("rst2 err", err0, 32'h0);
    chk("rst2 strobe", str0, 32'h0);
    rst     = 1'b1;
    load_en = 1'b0;
    pc      = 8'd3;
    en0     = 1'b1;
    q0.push_back('{cyc + 2, 16'h1234, 1'b0});
    tick();
    en0 = 1'b0;
    pc  = 8'd10;
    en7 = 1'b1;
    q7.push_back('{cyc + 7, 16'h1010, 1'b0});
    tick();
    en7 = 1'b0;
    repeat (10) tick();

    pend("lat2", q0.size());
    pend("lat1", q1.size());
    pend("lat7", q7.size());
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
